// File: rtl/csr_commit_ctrl_pkg.sv
package csr_commit_ctrl_pkg;

  localparam logic [1:0] CSR_OP_NONE = 2'b00;
  localparam logic [1:0] CSR_OP_RD   = 2'b01;
  localparam logic [1:0] CSR_OP_WR   = 2'b10;
  localparam logic [1:0] CSR_OP_XCHG = 2'b11;

  localparam int unsigned EXC_W    = 6;
  localparam int unsigned EXC_SYS  = 0;
  localparam int unsigned EXC_INE  = 1;
  localparam int unsigned EXC_BRK  = 2;
  localparam int unsigned EXC_ALE  = 3;
  localparam int unsigned EXC_ADEF = 4;
  localparam int unsigned EXC_INT  = 5;

  typedef enum logic {
    ST_IDLE,
    ST_REDIR
  } state_t;

  typedef int unsigned exc_prio_t [EXC_W];

  // Highest priority first.
  localparam exc_prio_t EXC_PRIO = '{EXC_INT, EXC_ADEF, EXC_INE, EXC_BRK, EXC_SYS, EXC_ALE};

endpackage

// File: rtl/csr_commit_ctrl_exc_prio_sel.sv
module exc_prio_sel
  import csr_commit_ctrl_pkg::*;
(
  input  logic [EXC_W-1:0] raw,
  output logic [EXC_W-1:0] sel
);

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    sel = '0;
    for (int unsigned i = EXC_W; i > 0; i--) begin
      if (raw[EXC_PRIO[i-1]]) begin
        sel = '0;
        sel[EXC_PRIO[i-1]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/csr_commit_ctrl.sv
module csr_commit_ctrl
  import csr_commit_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter int unsigned CSR_NUM_W = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ws_valid,
  input  logic [31:0]          ws_pc,
  input  logic [4:0]           ws_exc_raw,
  input  logic                 ws_is_ertn,
  input  logic [1:0]           ws_csr_op,
  input  logic [CSR_NUM_W-1:0] ws_csr_num,
  input  logic [31:0]          ws_rj_value,
  input  logic [31:0]          ws_rd_value,
  input  logic                 has_int,
  input  logic [31:0]          csr_eentry_pc,
  input  logic [31:0]          csr_eertn_pc,
  input  logic                 redirect_ready,
  output logic [5:0]           exc,
  output logic                 ertn_flush,
  output logic [31:0]          wb_pc,
  output logic                 csr_re,
  output logic [CSR_NUM_W-1:0] csr_rd_num,
  output logic                 csr_we,
  output logic [CSR_NUM_W-1:0] csr_wr_num,
  output logic [31:0]          csr_wr_mask,
  output logic [31:0]          csr_wr_value,
  output logic                 ws_commit,
  output logic                 flush_all,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc
);

  // RESET_PC is bookkeeping only; redirect targets always come from the CSR file.
  if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_unaligned
  end

  state_t           state;
  state_t           state_nxt;
  logic             int_pending;
  logic [31:0]      redirect_pc_q;
  logic [31:0]      redirect_pc_nxt;
  logic             take;
  logic             trap;
  logic             ertn;
  logic [EXC_W-1:0] exc_raw;
  logic [EXC_W-1:0] exc_sel;

  // Outputs are forced quiet during the reset cycle even though reset is sampled synchronously.
  assign take    = (state == ST_IDLE) & ws_valid & ~reset;
  assign exc_raw = take ? {int_pending & has_int, ws_exc_raw} : '0;

  exc_prio_sel u_exc_prio_sel (
    .raw (exc_raw),
    .sel (exc_sel)
  );

  assign trap = |exc_sel;

  always_comb begin
    state_nxt       = state;
    redirect_pc_nxt = redirect_pc_q;
    ertn            = 1'b0;
    exc             = '0;
    ertn_flush      = 1'b0;
    wb_pc           = '0;
    csr_re          = 1'b0;
    csr_rd_num      = '0;
    csr_we          = 1'b0;
    csr_wr_num      = '0;
    csr_wr_mask     = '0;
    csr_wr_value    = '0;
    ws_commit       = 1'b0;
    flush_all       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;

    unique case (state)
      ST_IDLE: begin
        if (take) begin
          exc          = exc_sel;
          wb_pc        = ws_pc;
          csr_rd_num   = ws_csr_num;
          csr_wr_num   = ws_csr_num;
          csr_wr_value = ws_rd_value;
          if (trap) begin
            flush_all       = 1'b1;
            state_nxt       = ST_REDIR;
            redirect_pc_nxt = csr_eentry_pc;
          end else begin
            ws_commit = 1'b1;
            csr_re    = (ws_csr_op != CSR_OP_NONE);
            csr_we    = ws_csr_op[1];
            case (ws_csr_op)
              CSR_OP_WR:   csr_wr_mask = '1;
              CSR_OP_XCHG: csr_wr_mask = ws_rj_value;
              CSR_OP_RD,
              CSR_OP_NONE: csr_wr_mask = '0;
              default:     csr_wr_mask = '0;
            endcase
            if (ws_is_ertn) begin
              ertn            = 1'b1;
              ertn_flush      = 1'b1;
              flush_all       = 1'b1;
              state_nxt       = ST_REDIR;
              redirect_pc_nxt = csr_eertn_pc;
            end
          end
        end
      end
      ST_REDIR: begin
        if (!reset) begin
          redirect_valid = 1'b1;
          redirect_pc    = redirect_pc_q;
          flush_all      = 1'b1;
          if (redirect_ready) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      int_pending   <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state         <= state_nxt;
      int_pending   <= has_int & ~(trap | ertn);
      redirect_pc_q <= redirect_pc_nxt;
    end
  end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
module tb_csr_commit_ctrl;

  logic        clk;
  logic        reset;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic [4:0]  ws_exc_raw;
  logic        ws_is_ertn;
  logic [1:0]  ws_csr_op;
  logic [13:0] ws_csr_num;
  logic [31:0] ws_rj_value;
  logic [31:0] ws_rd_value;
  logic        has_int;
  logic [31:0] csr_eentry_pc;
  logic [31:0] csr_eertn_pc;
  logic        redirect_ready;
  logic [5:0]  exc;
  logic        ertn_flush;
  logic [31:0] wb_pc;
  logic        csr_re;
  logic [13:0] csr_rd_num;
  logic        csr_we;
  logic [13:0] csr_wr_num;
  logic [31:0] csr_wr_mask;
  logic [31:0] csr_wr_value;
  logic        ws_commit;
  logic        flush_all;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int tests = 0;
  int fails = 0;

  csr_commit_ctrl #(
    .RESET_PC  (32'h1c000000),
    .CSR_NUM_W (14)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ws_valid       (ws_valid),
    .ws_pc          (ws_pc),
    .ws_exc_raw     (ws_exc_raw),
    .ws_is_ertn     (ws_is_ertn),
    .ws_csr_op      (ws_csr_op),
    .ws_csr_num     (ws_csr_num),
    .ws_rj_value    (ws_rj_value),
    .ws_rd_value    (ws_rd_value),
    .has_int        (has_int),
    .csr_eentry_pc  (csr_eentry_pc),
    .csr_eertn_pc   (csr_eertn_pc),
    .redirect_ready (redirect_ready),
    .exc            (exc),
    .ertn_flush     (ertn_flush),
    .wb_pc          (wb_pc),
    .csr_re         (csr_re),
    .csr_rd_num     (csr_rd_num),
    .csr_we         (csr_we),
    .csr_wr_num     (csr_wr_num),
    .csr_wr_mask    (csr_wr_mask),
    .csr_wr_value   (csr_wr_value),
    .ws_commit      (ws_commit),
    .flush_all      (flush_all),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: pending-redirect flag, held target, sampled interrupt.
  bit          m_redir = 1'b0;
  logic [31:0] m_rpc   = '0;
  bit          m_intp  = 1'b0;
  // Priority order as bit positions of exc: INT, ADEF, INE, BRK, SYS, ALE.
  int          prio [6] = '{5, 4, 1, 2, 0, 3};

  logic [5:0]  e_exc;
  logic        e_ertn, e_re, e_we, e_commit, e_flush, e_rv;
  logic [31:0] e_wbpc, e_mask, e_val, e_rpc;
  logic [13:0] e_rnum, e_wnum;
  logic [5:0]  cand;
  bit          n_redir, n_intp;
  logic [31:0] n_rpc;

  always @(negedge clk) begin
    e_exc = '0; e_ertn = 0; e_re = 0; e_we = 0; e_commit = 0; e_flush = 0; e_rv = 0;
    e_wbpc = '0; e_mask = '0; e_val = '0; e_rpc = '0; e_rnum = '0; e_wnum = '0;
    n_redir = m_redir; n_rpc = m_rpc; n_intp = has_int;
    if (reset) begin
      n_redir = 0; n_rpc = '0; n_intp = 0;
    end else if (m_redir) begin
      e_rv = 1; e_rpc = m_rpc; e_flush = 1;
      if (redirect_ready) n_redir = 0;
    end else if (ws_valid) begin
      cand = {m_intp & has_int, ws_exc_raw};
      for (int k = 0; k < 6; k++)
        if (e_exc == 6'd0 && cand[prio[k]]) e_exc[prio[k]] = 1'b1;
      e_wbpc = ws_pc; e_rnum = ws_csr_num; e_wnum = ws_csr_num; e_val = ws_rd_value;
      if (e_exc != 6'd0) begin
        e_flush = 1; n_redir = 1; n_rpc = csr_eentry_pc; n_intp = 0;
      end else begin
        e_commit = 1;
        e_re = (ws_csr_op != 2'd0);
        e_we = (ws_csr_op == 2'd2) || (ws_csr_op == 2'd3);
        e_mask = (ws_csr_op == 2'd2) ? 32'hffffffff : (ws_csr_op == 2'd3) ? ws_rj_value : 32'h0;
        if (ws_is_ertn) begin
          e_ertn = 1; e_flush = 1; n_redir = 1; n_rpc = csr_eertn_pc; n_intp = 0;
        end
      end
    end
    chk("m.exc", exc, e_exc);
    chk("m.ertn_flush", ertn_flush, e_ertn);
    chk("m.wb_pc", wb_pc, e_wbpc);
    chk("m.csr_re", csr_re, e_re);
    chk("m.csr_rd_num", csr_rd_num, e_rnum);
    chk("m.csr_we", csr_we, e_we);
    chk("m.csr_wr_num", csr_wr_num, e_wnum);
    chk("m.csr_wr_mask", csr_wr_mask, e_mask);
    chk("m.csr_wr_value", csr_wr_value, e_val);
    chk("m.ws_commit", ws_commit, e_commit);
    chk("m.flush_all", flush_all, e_flush);
    chk("m.redirect_valid", redirect_valid, e_rv);
    chk("m.redirect_pc", redirect_pc, e_rpc);
    m_redir = n_redir; m_rpc = n_rpc; m_intp = n_intp;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    ws_valid = 0; ws_pc = '0; ws_exc_raw = '0; ws_is_ertn = 0; ws_csr_op = 2'd0;
    ws_csr_num = '0; ws_rj_value = '0; ws_rd_value = '0; redirect_ready = 0;
  endtask

  initial begin
    reset = 1; has_int = 0; csr_eentry_pc = 32'h1c008000; csr_eertn_pc = 32'h1c00dead;
    clr();
    // Reset: even a valid trapping instruction produces nothing.
    ws_valid = 1; ws_exc_raw = 5'b00001; ws_csr_op = 2'd2;
    sample();
    chk("rst.exc", exc, 6'd0);
    chk("rst.flush_all", flush_all, 0);
    chk("rst.ws_commit", ws_commit, 0);
    chk("rst.csr_we", csr_we, 0);
    step();
    step(); reset = 0; clr();
    sample();
    chk("idle.redirect_valid", redirect_valid, 0);
    chk("idle.wb_pc", wb_pc, 32'h0);

    // csrxchg
    step(); clr(); ws_valid = 1; ws_csr_op = 2'd3; ws_csr_num = 14'h30;
    ws_rj_value = 32'h0000ff00; ws_rd_value = 32'h12345678; ws_pc = 32'h1c000040;
    sample();
    chk("xchg.csr_we", csr_we, 1);
    chk("xchg.mask", csr_wr_mask, 32'h0000ff00);
    chk("xchg.value", csr_wr_value, 32'h12345678);
    chk("xchg.csr_re", csr_re, 1);
    chk("xchg.wr_num", csr_wr_num, 14'h30);
    chk("xchg.commit", ws_commit, 1);
    chk("xchg.redirect_valid", redirect_valid, 0);

    // csrrd
    step(); clr(); ws_valid = 1; ws_csr_op = 2'd1; ws_csr_num = 14'h5; ws_rd_value = 32'h55;
    sample();
    chk("rd.csr_re", csr_re, 1);
    chk("rd.csr_we", csr_we, 0);
    chk("rd.rd_num", csr_rd_num, 14'h5);
    chk("rd.mask", csr_wr_mask, 32'h0);

    // SYS trap, redirect held for 3 cycles
    step(); clr(); ws_valid = 1; ws_exc_raw = 5'b00001; ws_pc = 32'h1c000100;
    sample();
    chk("sys.exc", exc, 6'b000001);
    chk("sys.wb_pc", wb_pc, 32'h1c000100);
    chk("sys.flush_all", flush_all, 1);
    chk("sys.commit", ws_commit, 0);
    for (int c = 0; c < 3; c++) begin
      step(); clr(); ws_valid = 1; ws_csr_op = 2'd2; ws_pc = 32'h1c000104;
      csr_eentry_pc = 32'h1c00fff0;
      sample();
      chk("sysr.redirect_valid", redirect_valid, 1);
      chk("sysr.redirect_pc", redirect_pc, 32'h1c008000);
      chk("sysr.csr_we", csr_we, 0);
      chk("sysr.commit", ws_commit, 0);
      chk("sysr.exc", exc, 6'd0);
    end
    csr_eentry_pc = 32'h1c008000;
    step(); clr(); redirect_ready = 1;
    sample();
    chk("sysr.accept_valid", redirect_valid, 1);
    step(); clr();
    sample();
    chk("sys.back_idle", redirect_valid, 0);

    // ADEF+ALE+SYS with csrwr, single-cycle redirect
    step(); clr(); ws_valid = 1; ws_exc_raw = 5'b11001; ws_csr_op = 2'd2; ws_pc = 32'h1c000200;
    sample();
    chk("multi.exc", exc, 6'b010000);
    chk("multi.csr_we", csr_we, 0);
    step(); clr(); redirect_ready = 1;
    sample();
    chk("multi.redirect_pc", redirect_pc, 32'h1c008000);
    step(); clr();
    sample();
    chk("multi.single_redir", redirect_valid, 0);

    // Interrupt overrides csrwr + ertn
    step(); clr(); has_int = 1;
    step(); clr();
    step(); clr(); ws_valid = 1; ws_csr_op = 2'd2; ws_is_ertn = 1; ws_pc = 32'h1c000300;
    sample();
    chk("int.exc", exc, 6'b100000);
    chk("int.csr_we", csr_we, 0);
    chk("int.commit", ws_commit, 0);
    chk("int.ertn_flush", ertn_flush, 0);
    step(); clr(); has_int = 0; redirect_ready = 1;
    step(); clr();

    // ertn, with has_int only now rising (not yet sampled)
    step(); clr(); csr_eertn_pc = 32'h1c000104; has_int = 1;
    ws_valid = 1; ws_is_ertn = 1; ws_pc = 32'h1c000400;
    sample();
    chk("ertn.flush", ertn_flush, 1);
    chk("ertn.commit", ws_commit, 1);
    chk("ertn.exc", exc, 6'd0);
    step(); clr(); redirect_ready = 1; ws_valid = 1; ws_csr_op = 2'd2;
    sample();
    chk("ertn.redirect_pc", redirect_pc, 32'h1c000104);
    chk("ertn.redir_we", csr_we, 0);
    // has_int sampled during REDIR, taken on first valid instruction in IDLE
    step(); clr(); ws_valid = 1; ws_pc = 32'h1c000104;
    sample();
    chk("int2.exc", exc, 6'b100000);
    step(); clr(); has_int = 0; redirect_ready = 1;
    step(); clr();

    // Reset on second REDIR cycle
    step(); clr(); ws_valid = 1; ws_exc_raw = 5'b00100;
    sample();
    chk("brk.exc", exc, 6'b000100);
    step(); clr();
    sample();
    chk("rr.redir1", redirect_valid, 1);
    step(); clr(); reset = 1;
    sample();
    chk("rr.rst_valid", redirect_valid, 0);
    chk("rr.rst_flush", flush_all, 0);
    step(); clr(); reset = 0;
    sample();
    chk("rr.after_valid", redirect_valid, 0);
    chk("rr.after_flush", flush_all, 0);
    chk("rr.after_exc", exc, 6'd0);
    step(); clr(); ws_valid = 1; ws_csr_op = 2'd2; ws_rd_value = 32'hcafe0001;
    sample();
    chk("rr.idle_we", csr_we, 1);
    chk("rr.idle_mask", csr_wr_mask, 32'hffffffff);

    step(); clr();
    sample();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
